// File: rtl/aes_inv_key_expand.sv
// Inverse AES-128 key schedule: walks round keys 10..0 backwards over a valid/ready handshake.
// Optional build macro AES_INV_KEY_EQINV_EN emits InvMixColumns(key) for rounds 9..1.

module key_sub_b (
   input  logic [31:0] word_i,
   output logic [31:0] word_o
);

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] acc;
      logic [7:0] t;
      acc = '0;
      t   = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) acc = acc ^ t;
         t = xtime(t);
      end
      return acc;
   endfunction

   // Multiplicative inverse as x^254 (maps 0 to 0), followed by the AES affine map.
   function automatic logic [7:0] sbox(input logic [7:0] x);
      logic [7:0] inv;
      inv = 8'h01;
      for (int i = 7; i >= 0; i--) begin
         inv = gf_mul(inv, inv);
         if (i != 0) inv = gf_mul(inv, x);
      end
      return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                 ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   endfunction

   for (genvar b = 0; b < 4; b++) begin : g_byte
      assign word_o[8*b +: 8] = sbox(word_i[8*b +: 8]);
   end

endmodule

module aes_inv_key_expand #(
   parameter int unsigned NR = 10
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [127:0] key_in,
   output logic         busy,
   output logic         rk_valid,
   input  logic         rk_ready,
   output logic [127:0] rk_out,
   output logic [3:0]   rk_idx,
   output logic         done
);

   localparam logic [3:0] IDX_TOP  = 4'(NR);
   localparam logic [7:0] RCON_TOP = 8'h36;

   typedef enum logic [1:0] {IDLE, EMIT, DONE} state_t;

   state_t       state_q, state_d;
   logic [127:0] key_q, key_d;
   logic [7:0]   rcon_q, rcon_d;
   logic [3:0]   idx_q, idx_d;
   logic         busy_q, busy_d;
   logic         valid_q, valid_d;

   logic [31:0]  w0, w1, w2, w3;
   logic [31:0]  p0, p1, p2, p3;
   logic [31:0]  rot_w, sub_w;
   logic [127:0] prev_key;
   logic [7:0]   rcon_next;

   assign w0 = key_q[31:0];
   assign w1 = key_q[63:32];
   assign w2 = key_q[95:64];
   assign w3 = key_q[127:96];

   assign p3 = w3 ^ w2;
   assign p2 = w2 ^ w1;
   assign p1 = w1 ^ w0;

   // RotWord before SubWord: the byte-wise S-box commutes with the rotation.
   assign rot_w = {p3[7:0], p3[31:24], p3[23:16], p3[15:8]};

   key_sub_b u_sub (
      .word_i (rot_w),
      .word_o (sub_w)
   );

   assign p0       = w0 ^ sub_w ^ {24'h0, rcon_q};
   assign prev_key = {p3, p2, p1, p0};

   always_comb begin
      case (rcon_q)
         8'h36:   rcon_next = 8'h1b;
         8'h1b:   rcon_next = 8'h80;
         default: rcon_next = {1'b0, rcon_q[7:1]};
      endcase
   end

   always_comb begin
      // NOTE: every next-state signal takes its hold value first so no path infers a latch.
      state_d = state_q;
      key_d   = key_q;
      rcon_d  = rcon_q;
      idx_d   = idx_q;
      busy_d  = busy_q;
      valid_d = valid_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               key_d   = key_in;
               idx_d   = IDX_TOP;
               rcon_d  = RCON_TOP;
               busy_d  = 1'b1;
               valid_d = 1'b1;
               state_d = EMIT;
            end
         end
         EMIT: begin
            if (rk_ready) begin
               if (idx_q == 4'd0) begin
                  valid_d = 1'b0;
                  state_d = DONE;
               end else begin
                  key_d  = prev_key;
                  idx_d  = idx_q - 4'd1;
                  rcon_d = rcon_next;
               end
            end
         end
         DONE: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         // NOTE: the key register is cleared on reset so no partial key survives an abort.
         key_q   <= '0;
         rcon_q  <= RCON_TOP;
         idx_q   <= '0;
         busy_q  <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         key_q   <= key_d;
         rcon_q  <= rcon_d;
         idx_q   <= idx_d;
         busy_q  <= busy_d;
         valid_q <= valid_d;
      end
   end

`ifdef AES_INV_KEY_EQINV_EN
   function automatic logic [7:0] xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
      logic [7:0] a [4];
      logic [7:0] m9 [4];
      logic [7:0] mb [4];
      logic [7:0] md [4];
      logic [7:0] me [4];
      logic [7:0] x2, x4, x8;
      for (int j = 0; j < 4; j++) begin
         a[j]  = col[8*j +: 8];
         x2    = xt(a[j]);
         x4    = xt(x2);
         x8    = xt(x4);
         m9[j] = x8 ^ a[j];
         mb[j] = x8 ^ x2 ^ a[j];
         md[j] = x8 ^ x4 ^ a[j];
         me[j] = x8 ^ x4 ^ x2;
      end
      return {mb[0] ^ md[1] ^ m9[2] ^ me[3],
              md[0] ^ m9[1] ^ me[2] ^ mb[3],
              m9[0] ^ me[1] ^ mb[2] ^ md[3],
              me[0] ^ mb[1] ^ md[2] ^ m9[3]};
   endfunction

   logic [127:0] out_q, out_d;

   // The transform is computed from next-state so the output register stays aligned with idx.
   always_comb begin
      out_d = key_d;
      if (idx_d != 4'd0 && idx_d != IDX_TOP) begin
         for (int c = 0; c < 4; c++) out_d[32*c +: 32] = inv_mix_col(key_d[32*c +: 32]);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) out_q <= '0;
      else     out_q <= out_d;
   end

   assign rk_out = out_q;
`else
   assign rk_out = key_q;
`endif

   assign busy     = busy_q;
   assign rk_valid = valid_q;
   assign rk_idx   = idx_q;
   assign done     = (state_q == DONE);

endmodule

// File: doc/aes_inv_key_expand.md
Name: aes_inv_key_expand

Overview:
- Inverse AES-128 key schedule for the decryption datapath.
- Takes the round-10 key and walks the schedule backwards, emitting round keys 10, 9, …, 0 one at a time over a valid/ready handshake.
- Undoes the forward g()/word-XOR chain, so the decrypt core needs no stored copy of the full expanded schedule.

Parameters:
- NR, 10, number of rounds; fixed at 10 for AES-128. Sets the initial rk_idx and the Rcon start point.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request; sampled only in IDLE.
- key_in  input  128  round-10 key. Byte order: FIPS byte k at [8k+7:8k]; word j at [32j+31:32j].
- busy  output  1  high from start acceptance until the round-0 handshake.
- rk_valid  output  1  rk_out/rk_idx hold a valid round key.
- rk_ready  input  1  consumer accepts the key when rk_valid && rk_ready.
- rk_out  output  128  current round key, same byte order as key_in.
- rk_idx  output  4  round number of rk_out (10..0).
- done  output  1  one-cycle pulse after the round-0 handshake.

Behaviour:
- Reset (async, any state): state=IDLE; busy=0, rk_valid=0, done=0, rk_out=0, rk_idx=0; Rcon register=0x36.
- FSM states: IDLE, EMIT, DONE.
- IDLE -> EMIT on start:
  - capture key_in into the key register.
  - rk_idx<=NR, rcon<=0x36, busy<=1.
  - rk_valid=1 on the next cycle (latency 1).
- EMIT, stall: rk_valid stays high; rk_out and rk_idx are held stable while !rk_ready.
- EMIT, handshake with rk_idx>0: next cycle loads the previous round key.
  - rk_idx decrements; rk_valid stays high.
  - Throughput: 1 key per cycle.
- EMIT, handshake with rk_idx==0: go to DONE; rk_valid<=0.
- DONE: done=1 for exactly one cycle, busy<=0, then IDLE.
- start is ignored outside IDLE. start in the same cycle as the DONE->IDLE transition is also ignored; it is accepted from the following cycle.
- Inverse step, with current words w0..w3:
  - p3=w3^w2, p2=w2^w1, p1=w1^w0.
  - p0 = w0 ^ g(p3).
  - g(x) = {S(x[7:0]), S(x[31:24]), S(x[23:16]), S(x[15:8])^rcon}, listed MSB-first (RotWord + SubWord + Rcon on byte 0).
- S-box: forward S-box only, as 4 combinational byte lookups; reuse the team's existing 4-byte S-box module key_sub_b.
- rcon is the Rcon of the round being undone (round rk_idx). Sequence as rk_idx goes 10..1: 36, 1b, 80, 40, 20, 10, 08, 04, 02, 01.
- Rcon update after each step: 0x36->0x1b, 0x1b->0x80, otherwise right shift by 1.
- rk_out is driven from a register. No combinational path from rk_ready to rk_valid.
- Mid-operation reset: immediate return to IDLE with outputs cleared. No partial key is retained.

Optional Feature:
- Macro: AES_INV_KEY_EQINV_EN.
- Defined:
  - For rk_idx 9..1, rk_out = InvMixColumns(raw key), applied per 32-bit column, equivalent-inverse-cipher form.
  - Rounds 10 and 0 are output raw.
  - The key register always holds the raw key; the transform is applied on the output path only, and that path is registered.
  - Latency and handshake are unchanged.
- Undefined: rk_out is always the raw round key.

Test Plan:
- FIPS-197 round-10 key bytes d0 14 f9 a8 c9 ee 25 89 e1 3f 0c c8 b6 63 0c a6, rk_ready=1 -> 11 consecutive keys.
  - idx 9 = bytes ac 77 66 f3 19 fa dc 21 28 d1 29 41 57 5c 00 6e.
  - idx 0 = bytes 2b 7e 15 16 28 ae d2 a6 ab f7 15 88 09 cf 4f 3c.
  - done pulses 1 cycle after the idx-0 handshake.
- Same vector, rk_ready toggled pseudo-randomly -> identical key sequence; rk_out/rk_idx stable during every stall; no key skipped or duplicated.
- start pulsed again at idx 5 -> ignored; sequence continues to idx 0 unchanged.
- rst asserted while rk_idx==4 -> outputs 0 and busy=0 asynchronously; a fresh start then produces idx 10 first.
- Round-trip: random 128-bit key, forward-expanded in the software model, feed its round-10 key -> all 11 keys match the model; 1000 seeds.
- With AES_INV_KEY_EQINV_EN: FIPS vector -> idx 10 and idx 0 raw; idx 9..1 equal InvMixColumns of the raw keys per the model.
